// File: rtl/cmd_loader.sv
// UART command loader: collects charset lines, then seed and goal bytes,
// and writes them out as RAM strobes and committed registers.
module cmd_loader #(
    parameter int unsigned NUM_POS      = 8,
    parameter int unsigned MAX_CHARS    = 64,
    parameter int unsigned SEED_BYTES   = 4,
    parameter int unsigned GOAL_BYTES   = 4,
    parameter int unsigned TIMEOUT_CLKS = 100000
) (
    input  logic                           fpgaclk,
    input  logic                           reset,
    input  logic                           rx_valid,
    input  logic [7:0]                     rx_data,
    output logic                           cs_we,
    output logic [$clog2(NUM_POS)-1:0]     cs_pos,
    output logic [$clog2(MAX_CHARS)-1:0]   cs_idx,
    output logic [7:0]                     cs_char,
    output logic                           len_we,
    output logic [$clog2(MAX_CHARS+1)-1:0] len_val,
    output logic [8*SEED_BYTES-1:0]        seed,
    output logic [8*GOAL_BYTES-1:0]        goal,
    output logic                           cfg_done,
    output logic                           busy,
    output logic                           err,
    output logic [1:0]                     err_code
);
    localparam int unsigned PosW  = $clog2(NUM_POS);
    localparam int unsigned IdxW  = $clog2(MAX_CHARS);
    localparam int unsigned LenW  = $clog2(MAX_CHARS + 1);
    localparam int unsigned CntW  = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned BcntW = $clog2(SEED_BYTES + GOAL_BYTES + 1);
    localparam int unsigned SeedW = 8 * SEED_BYTES;
    localparam int unsigned GoalW = 8 * GOAL_BYTES;

    localparam logic [PosW-1:0]  LastPos  = PosW'(NUM_POS - 1);
    localparam logic [LenW-1:0]  FullIdx  = LenW'(MAX_CHARS);
    localparam logic [CntW-1:0]  LastIdle = CntW'(TIMEOUT_CLKS - 1);
    localparam logic [BcntW-1:0] LastSeed = BcntW'(SEED_BYTES - 1);
    localparam logic [BcntW-1:0] LastGoal = BcntW'(GOAL_BYTES - 1);

    typedef enum logic [1:0] {StCharset, StSeed, StGoal} state_e;

    state_e            state_q, state_d;
    logic [PosW-1:0]   pos_q, pos_d;
    logic [LenW-1:0]   idx_q, idx_d;
    logic [BcntW-1:0]  bcnt_q, bcnt_d;
    logic [CntW-1:0]   idle_q, idle_d;
    logic [SeedW-1:0]  seed_sh_q, seed_sh_d, seed_q, seed_d;
    logic [GoalW-1:0]  goal_sh_q, goal_sh_d, goal_q, goal_d;
    logic              cs_we_q, cs_we_d, len_we_q, len_we_d;
    logic              cfg_done_q, cfg_done_d, err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [PosW-1:0]   cs_pos_q, cs_pos_d;
    logic [IdxW-1:0]   cs_idx_q, cs_idx_d;
    logic [7:0]        cs_char_q, cs_char_d;
    logic [LenW-1:0]   len_val_q, len_val_d;
    logic              abort;

    assign busy = (state_q != StCharset) || (pos_q != '0) || (idx_q != '0);

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        seed_sh_d  = seed_sh_q;
        goal_sh_d  = goal_sh_q;
        seed_d     = seed_q;
        goal_d     = goal_q;
        cs_pos_d   = cs_pos_q;
        cs_idx_d   = cs_idx_q;
        cs_char_d  = cs_char_q;
        len_val_d  = len_val_q;
        err_code_d = err_code_q;
        cs_we_d    = 1'b0;
        len_we_d   = 1'b0;
        cfg_done_d = 1'b0;
        err_d      = 1'b0;
        abort      = 1'b0;

        if (rx_valid) begin
            idle_d = '0;
        end else if (busy) begin
            idle_d = idle_q + CntW'(1);
        end else begin
            idle_d = '0;
        end

        if (rx_valid) begin
            unique case (state_q)
                StCharset: begin
                    cs_pos_d  = pos_q;
                    cs_idx_d  = IdxW'(idx_q);
                    cs_char_d = rx_data;
                    if (rx_data == 8'h0A) begin
                        if (idx_q == '0) begin
                            err_d      = 1'b1;
                            err_code_d = 2'd2;
                            abort      = 1'b1;
                        end else begin
                            len_we_d  = 1'b1;
                            len_val_d = idx_q;
                            idx_d     = '0;
                            if (pos_q == LastPos) begin
                                state_d = StSeed;
                                pos_d   = '0;
                                bcnt_d  = '0;
                            end else begin
                                pos_d = pos_q + PosW'(1);
                            end
                        end
                    end else if (idx_q == FullIdx) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        abort      = 1'b1;
                    end else begin
                        cs_we_d = 1'b1;
                        idx_d   = idx_q + LenW'(1);
                    end
                end
                StSeed: begin
                    seed_sh_d = (seed_sh_q << 8) | SeedW'(rx_data);
                    if (bcnt_q == LastSeed) begin
                        state_d = StGoal;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + BcntW'(1);
                    end
                end
                StGoal: begin
                    goal_sh_d = (goal_sh_q << 8) | GoalW'(rx_data);
                    if (bcnt_q == LastGoal) begin
                        seed_d     = seed_sh_q;
                        goal_d     = goal_sh_d;
                        cfg_done_d = 1'b1;
                        abort      = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + BcntW'(1);
                    end
                end
                default: abort = 1'b1;
            endcase
        end else if (busy && (idle_q == LastIdle)) begin
            // A byte on this same cycle takes priority over the timeout.
            err_d      = 1'b1;
            err_code_d = 2'd3;
            abort      = 1'b1;
        end

        if (abort) begin
            state_d = StCharset;
            pos_d   = '0;
            idx_d   = '0;
            bcnt_d  = '0;
            idle_d  = '0;
        end
    end

    always_ff @(posedge fpgaclk) begin
        if (reset) begin
            state_q    <= StCharset;
            pos_q      <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            idle_q     <= '0;
            seed_sh_q  <= '0;
            goal_sh_q  <= '0;
            seed_q     <= '0;
            goal_q     <= '0;
            cs_we_q    <= 1'b0;
            len_we_q   <= 1'b0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            cs_pos_q   <= '0;
            cs_idx_q   <= '0;
            cs_char_q  <= '0;
            len_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            idle_q     <= idle_d;
            seed_sh_q  <= seed_sh_d;
            goal_sh_q  <= goal_sh_d;
            seed_q     <= seed_d;
            goal_q     <= goal_d;
            cs_we_q    <= cs_we_d;
            len_we_q   <= len_we_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cs_pos_q   <= cs_pos_d;
            cs_idx_q   <= cs_idx_d;
            cs_char_q  <= cs_char_d;
            len_val_q  <= len_val_d;
        end
    end

    assign cs_we    = cs_we_q;
    assign cs_pos   = cs_pos_q;
    assign cs_idx   = cs_idx_q;
    assign cs_char  = cs_char_q;
    assign len_we   = len_we_q;
    assign len_val  = len_val_q;
    assign seed     = seed_q;
    assign goal     = goal_q;
    assign cfg_done = cfg_done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_cmd_loader.sv
// Scoreboard bench for cmd_loader: expected output events are queued as
// bytes are driven and matched against every strobe the DUT raises.
module tb_cmd_loader;
    logic        fpgaclk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        cs_we, len_we, cfg_done, busy, err;
    logic [2:0]  cs_pos, cs_idx, len_val;
    logic [7:0]  cs_char;
    logic [31:0] seed, goal;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;
    logic [71:0] exp_q[$];
    logic [71:0] mon_obs, mon_exp;

    cmd_loader #(
        .NUM_POS(8), .MAX_CHARS(6), .SEED_BYTES(4), .GOAL_BYTES(4), .TIMEOUT_CLKS(50)
    ) dut (
        .fpgaclk(fpgaclk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .cs_we(cs_we), .cs_pos(cs_pos), .cs_idx(cs_idx), .cs_char(cs_char),
        .len_we(len_we), .len_val(len_val), .seed(seed), .goal(goal),
        .cfg_done(cfg_done), .busy(busy), .err(err), .err_code(err_code)
    );

    always #5 fpgaclk = ~fpgaclk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Event word: {4'b0, kind{cs_we,len_we,cfg_done,err}, 64-bit payload}
    task automatic push_cs(input int p, input int i, input logic [7:0] c);
        exp_q.push_back({4'b0, 4'b1000, 40'd0, 8'(p), 8'(i), c});
    endtask
    task automatic push_len(input int p, input int l);
        exp_q.push_back({4'b0, 4'b0100, 48'd0, 8'(p), 8'(l)});
    endtask
    task automatic push_done(input logic [31:0] s, input logic [31:0] g);
        exp_q.push_back({4'b0, 4'b0010, s, g});
    endtask
    task automatic push_err(input int code);
        exp_q.push_back({4'b0, 4'b0001, 64'(code)});
    endtask

    always @(negedge fpgaclk) begin
        if (!reset && (cs_we || len_we || cfg_done || err)) begin
            mon_obs[71:68] = 4'b0;
            mon_obs[67:64] = {cs_we, len_we, cfg_done, err};
            if (cs_we)         mon_obs[63:0] = {40'd0, 8'(cs_pos), 8'(cs_idx), cs_char};
            else if (len_we)   mon_obs[63:0] = {48'd0, 8'(cs_pos), 8'(len_val)};
            else if (cfg_done) mon_obs[63:0] = {seed, goal};
            else               mon_obs[63:0] = 64'(err_code);
            if (exp_q.size() == 0) begin
                check("unexpected_event", mon_obs, 72'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", mon_obs, mon_exp);
            end
        end
    end

    // Caller is just past a rising edge; the byte is sampled on the next one.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge fpgaclk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_line(input string s, input int p);
        for (int i = 0; i < s.len(); i++) begin
            push_cs(p, i, s[i]);
            send(s[i]);
        end
        push_len(p, s.len());
        send(8'h0A);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send(w[31-8*k -: 8]);
    endtask

    task automatic send_lines();
        for (int p = 0; p < 8; p++) send_line((p % 2 == 0) ? "QR" : "xyz", p);
    endtask

    task automatic full_cfg(input logic [31:0] s, input logic [31:0] g);
        send_lines();
        send_word(s);
        push_done(s, g);
        send_word(g);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge fpgaclk);
        #1;
        check(tag, 72'(exp_q.size()), 72'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge fpgaclk);
        #1;
        send(8'h41);
        send(8'h0A);
        check("rst_flags", 72'({cs_we, len_we, cfg_done, err, busy, err_code}), 72'd0);
        check("rst_data", 72'({cs_pos, cs_idx, cs_char, len_val}), 72'd0);
        check("rst_seed_goal", 72'({seed, goal}), 72'd0);
        reset = 1'b0;
        @(posedge fpgaclk);
        #1;

        // Reference configuration: 5 one-char lines, 3 six-char lines.
        for (int p = 0; p < 5; p++) send_line("A", p);
        for (int p = 5; p < 8; p++) send_line("AGILMY", p);
        send(8'h04);
        check("busy_in_seed", 72'(busy), 72'd1);
        send(8'h82);
        send(8'h14);
        send(8'h27);
        send(8'h32);
        send(8'h6F);
        send(8'h4D);
        check("seed_before_commit", 72'({seed, goal}), 72'd0);
        push_done(32'h04821427, 32'h326F4D9C);
        send(8'h9C);
        check("cfg_done_latency", 72'(cfg_done), 72'd1);
        check("seed_goal_commit", 72'({seed, goal}), 72'h04821427_326F4D9C);
        check("busy_after_commit", 72'(busy), 72'd0);
        drain("drain_ref_cfg");

        // Overflow: the seventh character on a 6-wide line.
        for (int i = 0; i < 6; i++) begin
            push_cs(0, i, 8'h41 + 8'(i));
            send(8'h41 + 8'(i));
        end
        push_err(1);
        send(8'h47);
        check("busy_after_overflow", 72'(busy), 72'd0);
        drain("drain_overflow");

        // Empty line as first byte, then after a valid line.
        push_err(2);
        send(8'h0A);
        check("busy_after_empty", 72'(busy), 72'd0);
        send_line("B", 0);
        push_err(2);
        send(8'h0A);
        drain("drain_empty");

        // Timeout exactly 50 clocks after the last byte.
        push_cs(0, 0, 8'h41);
        send(8'h41);
        repeat (49) @(posedge fpgaclk);
        @(negedge fpgaclk);
        #1;
        push_err(3);
        repeat (3) @(posedge fpgaclk);
        #1;
        check("busy_after_timeout", 72'(busy), 72'd0);
        check("seed_kept_timeout", 72'({seed, goal}), 72'h04821427_326F4D9C);
        drain("drain_timeout");

        // New configuration; old values hold until the final goal byte.
        send_lines();
        send_word(32'hDEADBEEF);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        check("seed_kept_partial", 72'({seed, goal}), 72'h04821427_326F4D9C);
        push_done(32'hDEADBEEF, 32'h01020304);
        send(8'h04);
        check("seed_goal_commit2", 72'({seed, goal}), 72'hDEADBEEF_01020304);
        drain("drain_cfg2");

        // Byte landing on the 50th idle cycle wins over the timeout.
        push_cs(0, 0, 8'h41);
        send(8'h41);
        repeat (49) @(posedge fpgaclk);
        #1;
        push_cs(0, 1, 8'h42);
        send(8'h42);
        check("busy_after_gap_byte", 72'(busy), 72'd1);
        push_len(0, 2);
        send(8'h0A);
        push_err(3);
        repeat (55) @(posedge fpgaclk);
        #1;
        drain("drain_gap");

        // Reset in the goal phase discards everything.
        send_lines();
        send_word(32'h11223344);
        send(8'hAA);
        send(8'hBB);
        check("busy_in_goal", 72'(busy), 72'd1);
        reset = 1'b1;
        send(8'hCC);
        send(8'hDD);
        check("mid_rst_flags", 72'({cs_we, len_we, cfg_done, err, busy, err_code}), 72'd0);
        check("mid_rst_data", 72'({cs_pos, cs_idx, cs_char, len_val}), 72'd0);
        check("mid_rst_seed_goal", 72'({seed, goal}), 72'd0);
        reset = 1'b0;
        @(posedge fpgaclk);
        #1;
        full_cfg(32'hCAFEF00D, 32'h0BADC0DE);
        check("seed_goal_after_rst", 72'({seed, goal}), 72'hCAFEF00D_0BADC0DE);
        drain("drain_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmd_loader.md
CMD_LOADER -- requirements
Module: cmd_loader

Interface
REQ-001 SHALL have parameter NUM_POS, default 8: number of candidate character positions (charset lines) per configuration.
REQ-002 SHALL have parameter MAX_CHARS, default 64: maximum characters per charset line.
REQ-003 SHALL have parameter SEED_BYTES, default 4: seed length in bytes.
REQ-004 SHALL have parameter GOAL_BYTES, default 4: goal hash length in bytes.
REQ-005 SHALL have parameter TIMEOUT_CLKS, default 100000: maximum idle clocks between bytes of one configuration.
REQ-006 SHALL have port fpgaclk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port rx_valid  input  1  one-cycle strobe; a received UART byte is present on rx_data.
REQ-009 SHALL have port rx_data  input  8  received byte.
REQ-010 SHALL have port cs_we  output  1  charset RAM write strobe.
REQ-011 SHALL have port cs_pos  output  $clog2(NUM_POS)  position being written.
REQ-012 SHALL have port cs_idx  output  $clog2(MAX_CHARS)  character index within the position.
REQ-013 SHALL have port cs_char  output  8  character to write.
REQ-014 SHALL have port len_we  output  1  charset length write strobe.
REQ-015 SHALL have port len_val  output  $clog2(MAX_CHARS+1)  length of the completed line; it is written to position cs_pos.
REQ-016 SHALL have port seed  output  8*SEED_BYTES  last committed seed.
REQ-017 SHALL have port goal  output  8*GOAL_BYTES  last committed goal.
REQ-018 SHALL have port cfg_done  output  1  one-cycle pulse when a full configuration is committed.
REQ-019 SHALL have port busy  output  1  high while a configuration is partially received.
REQ-020 SHALL have port err  output  1  one-cycle error pulse.
REQ-021 SHALL have port err_code  output  2  error cause, valid with err: 1 = overflow, 2 = empty line, 3 = timeout.

Function
REQ-022 SHALL implement the states CHARSET, SEED and GOAL; the state after reset is CHARSET with pos=0 and idx=0.
REQ-023 In CHARSET, a byte other than 0x0A SHALL produce cs_we=1 with the current cs_pos, cs_idx and cs_char=byte, registered on the cycle after rx_valid; idx then increments.
REQ-024 In CHARSET, byte 0x0A with idx>0 SHALL produce len_we=1 with len_val=idx, registered on the cycle after rx_valid; idx then clears and pos increments.
REQ-025 After line NUM_POS-1 terminates, the block SHALL enter SEED; position wrap to a later line SHALL NOT occur.
REQ-026 In SEED and GOAL, bytes SHALL shift into shadow registers big-endian (first byte = MSB); no byte value is special.
REQ-027 After SEED_BYTES bytes the block SHALL enter GOAL; after GOAL_BYTES bytes it SHALL copy both shadow registers to seed and goal, pulse cfg_done on the next cycle, and return to CHARSET pos=0.
REQ-028 seed and goal SHALL change only on commit; a partial or aborted configuration SHALL leave them unchanged.
REQ-029 busy SHALL be 1 whenever state≠CHARSET or pos≠0 or idx≠0.
REQ-030 A non-0x0A byte arriving when idx==MAX_CHARS SHALL raise err with err_code=1, SHALL NOT write, and SHALL abort to CHARSET pos=0 idx=0.
REQ-031 Byte 0x0A arriving when idx==0 SHALL raise err with err_code=2 and SHALL abort.
REQ-032 An idle counter SHALL run while busy=1; it SHALL clear on every rx_valid; on reaching TIMEOUT_CLKS it SHALL raise err with err_code=3 and abort.
REQ-033 When rx_valid coincides with the timeout cycle, the byte SHALL win: it is processed and no timeout is raised.
REQ-034 Error and cfg_done pulses SHALL be mutually exclusive; at most one event SHALL be processed per rx_valid.

Reset
REQ-035 While reset=1, the block SHALL set cs_we, len_we, cfg_done, err, busy and err_code to 0, and set seed, goal, cs_pos, cs_idx, cs_char, len_val, all shadow registers and the idle counter to 0.
REQ-036 Reset asserted mid-configuration SHALL discard all partial state; rx_valid during reset SHALL be ignored.

Verification
REQ-037 With NUM_POS=8, send "A\n" ×5, then "AGILMY\n" ×3, then seed 04 82 14 27, then goal 32 6F 4D 9C -> expect 5 len_we with len_val=1 and 3 len_we with len_val=6 at pos 5..7, seed=0x04821427, goal=0x326F4D9C, one cfg_done pulse one cycle after the last byte.
REQ-038 With MAX_CHARS=4, send "ABCDE" -> expect 4 cs_we writes, then err with err_code=1 on the 'E' byte, busy=0 after it.
REQ-039 Send "\n" as the first byte -> expect err with err_code=2 and no len_we.
REQ-040 With TIMEOUT_CLKS=50, send "A" then idle 50 clocks -> expect err with err_code=3; then send a full configuration -> expect cfg_done, and seed/goal must still equal the previous commit until that commit.
REQ-041 With TIMEOUT_CLKS=50, place a byte exactly on cycle 50 of the gap -> expect no err and the byte is accepted.
REQ-042 Assert reset during the GOAL state -> expect all outputs 0 and busy=0; a following full configuration commits correctly.
